// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle instruction sequencer for twitchcore.
// Owns the PC and walks each instruction through FETCH, DECODE, EXECUTE,
// optional MEM and WRITEBACK. It handshakes with instruction and data memory,
// gates the register-file write, and keeps halt, fault and retire state.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned MEM_TIMEOUT = 16,   // >= 1
  parameter int unsigned TW          = 5     // 2**TW > MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        is_mem,
  input  logic        is_store,
  input  logic        illegal,
  input  logic        halt_req,
  input  logic        reg_writeback,
  input  logic [4:0]  rd,
  input  logic        pend_is_new_pc,
  input  logic [31:0] pend,
  output logic [31:0] pc,
  output logic [4:0]  stage,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_cnt;
  logic          r_store;
  logic [31:0]   r_pc;
  logic [31:0]   r_retired;
  logic [1:0]    r_fault;
  logic [4:0]    r_stage;
  logic          r_halted;

  logic          w_tmo;
  logic          w_restart;
  logic          w_set_fault;
  logic [1:0]    w_fault_val;
  logic          w_misalign;
  logic          w_waiting;

  assign w_tmo      = (r_cnt == TW'(MEM_TIMEOUT - 1));
  assign w_misalign = pend_is_new_pc && (pend[1:0] != 2'b00);
  assign w_waiting  = ((r_state == S_FETCH) && !imem_ready) ||
                      ((r_state == S_MEM)   && !dmem_ready);

  // One-hot {WB, MEM, EX, ID, IF} view of a state; zero in IDLE and HALT.
  function automatic logic [4:0] stage_of(input state_t s);
    case (s)
      S_FETCH:  stage_of = 5'b00001;
      S_DECODE: stage_of = 5'b00010;
      S_EXEC:   stage_of = 5'b00100;
      S_MEM:    stage_of = 5'b01000;
      S_WB:     stage_of = 5'b10000;
      default:  stage_of = '0;
    endcase
  endfunction

  // Next-state and combinational strobes/requests.
  always_comb begin
    w_next      = r_state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    retire      = 1'b0;
    w_restart   = 1'b0;
    w_set_fault = 1'b0;
    w_fault_val = '0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next    = S_FETCH;
          w_restart = 1'b1;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // A ready arriving on the final allowed cycle beats the timeout.
        if (imem_ready) begin
          w_next = S_DECODE;
        end else if (w_tmo) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
          w_fault_val = 2'd3;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
          w_fault_val = 2'd1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_store;
        if (dmem_ready) begin
          w_next = S_WB;
        end else if (w_tmo) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
          w_fault_val = 2'd3;
        end
      end
      S_WB: begin
        if (w_misalign) begin
          w_next      = S_HALT;
          w_set_fault = 1'b1;
          w_fault_val = 2'd2;
        end else begin
          retire = 1'b1;
          rf_we  = reg_writeback && (rd != 5'd0);
          w_next = halt_req ? S_HALT : S_FETCH;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Memory wait counter: cleared on every state entry, counts stalled cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (w_waiting)         r_cnt <= r_cnt + TW'(1);
  end

  // Latch load/store direction when EXECUTE commits to a memory access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          r_store <= 1'b0;
    else if ((r_state == S_EXEC) && is_mem) r_store <= is_store;
  end

  // Architectural state: PC, retire count and fault code.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_fault   <= '0;
    end else if (w_restart) begin
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_fault   <= '0;
    end else begin
      if (retire) begin
        r_retired <= r_retired + 32'd1;
        r_pc      <= pend_is_new_pc ? pend : r_pc + 32'd4;
      end
      if (w_set_fault) r_fault <= w_fault_val;
    end
  end

  // Registered status outputs, loaded from the upcoming state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stage  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_stage  <= stage_of(w_next);
      r_halted <= (w_next == S_HALT);
    end
  end

  assign pc      = r_pc;
  assign retired = r_retired;
  assign fault   = r_fault;
  assign stage   = r_stage;
  assign halted  = r_halted;

endmodule
